// File: rtl/sd_spi_master.sv
// Byte-oriented SPI master for SD cards: single-byte rd/wr with gapless chaining and two SCLK rates.
// Define SD_SPI_MASTER_LOOPBACK_EN to receive from the internal mosi instead of the miso pin.
module sd_spi_master #(
   parameter int HI_FREQ_DIV = 20,
   parameter int LO_FREQ_DIV = 358,
   parameter int SPI_MODE    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_div,
   input  logic       rd,
   input  logic       wr,
   input  logic       hold,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       done_tick,
   output logic       ready,
   input  logic       miso,
   output logic       mosi,
   output logic       sclk,
   output logic       cs_n,
   output logic [1:0] state_dbg
);

   localparam logic CPOL    = (SPI_MODE >= 2);
   localparam logic CPHA    = ((SPI_MODE % 2) == 1);
   localparam int   MAX_DIV = (HI_FREQ_DIV > LO_FREQ_DIV) ? HI_FREQ_DIV : LO_FREQ_DIV;
   localparam int   DW      = $clog2(MAX_DIV);
   localparam logic [DW-1:0] HI_M1  = DW'(HI_FREQ_DIV - 1);
   localparam logic [DW-1:0] LO_M1  = DW'(LO_FREQ_DIV - 1);
   localparam logic [DW-1:0] HI_HM1 = DW'(HI_FREQ_DIV / 2 - 1);
   localparam logic [DW-1:0] LO_HM1 = DW'(LO_FREQ_DIV / 2 - 1);
   localparam logic [DW-1:0] ONE    = DW'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      XFER      = 2'd1,
      HOLD_IDLE = 2'd2
   } state_t;

   state_t        state;
   logic [DW-1:0] cnt;
   logic [DW-1:0] div_m1;
   logic [DW-1:0] half_m1;
   logic [2:0]    bit_idx;
   logic [7:0]    tx_sr;
   logic [7:0]    rx_sr;
   logic [7:0]    rx_next;
   logic          rx_bit;
   logic          sample_now;
   logic          period_end;
   logic          byte_end;
   logic          start;

`ifdef SD_SPI_MASTER_LOOPBACK_EN
   assign rx_bit = mosi;
`else
   assign rx_bit = miso;
`endif

   assign state_dbg = state;

   // A request (rd|wr) is accepted in any cycle where ready=1 or the current
   // byte is in its done_tick cycle; rd/wr in any other cycle is dropped.
   always_comb begin
      sample_now = (state == XFER) && (cnt == half_m1);
      period_end = (state == XFER) && (cnt == div_m1);
      byte_end   = period_end && (bit_idx == 3'd7);
      start      = (rd | wr) && (ready | byte_end);
      rx_next    = sample_now ? {rx_sr[6:0], rx_bit} : rx_sr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         div_m1    <= LO_M1;
         half_m1   <= LO_HM1;
         bit_idx   <= 3'd0;
         tx_sr     <= 8'hFF;
         rx_sr     <= 8'h00;
         rd_data   <= 8'h00;
         done_tick <= 1'b0;
         ready     <= 1'b1;
         mosi      <= 1'b1;
         sclk      <= CPOL;
         cs_n      <= 1'b1;
      end else begin
         done_tick <= 1'b0;
         rx_sr     <= rx_next;
         if (start) begin
            // Start cycle doubles as the last clk of a finishing byte, so chains are gapless.
            state   <= XFER;
            ready   <= 1'b0;
            cs_n    <= 1'b0;
            cnt     <= '0;
            bit_idx <= 3'd0;
            div_m1  <= clk_div ? HI_M1 : LO_M1;
            half_m1 <= clk_div ? HI_HM1 : LO_HM1;
            tx_sr   <= wr ? {wr_data[6:0], 1'b1} : 8'hFF;
            mosi    <= wr ? wr_data[7] : 1'b1;
            sclk    <= CPHA ? ~CPOL : CPOL;
         end else begin
            case (state)
               XFER: begin
                  if (byte_end) begin
                     state <= hold ? HOLD_IDLE : IDLE;
                     cs_n  <= ~hold;
                     ready <= 1'b1;
                     mosi  <= 1'b1;
                     sclk  <= CPOL;
                  end else if (period_end) begin
                     cnt     <= '0;
                     bit_idx <= bit_idx + 3'd1;
                     mosi    <= tx_sr[7];
                     tx_sr   <= {tx_sr[6:0], 1'b1};
                     sclk    <= CPHA ? ~CPOL : CPOL;
                  end else begin
                     cnt <= cnt + ONE;
                     if (sample_now)
                        sclk <= CPHA ? CPOL : ~CPOL;
                     if ((cnt == div_m1 - ONE) && (bit_idx == 3'd7)) begin
                        done_tick <= 1'b1;
                        rd_data   <= rx_next;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed bench for sd_spi_master (mode 0): a slave model answers on miso, a monitor
// pops expected rd_data / mosi byte / completion cycle on every done_tick.
`timescale 1ns/1ps
module tb_sd_spi_master;

   localparam int HI = 20;
   localparam int LO = 358;
`ifdef SD_SPI_MASTER_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       clk_div = 1'b0, rd = 1'b0, wr = 1'b0, hold = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] rd_data;
   logic       done_tick, ready, miso, mosi, sclk, cs_n;
   logic [1:0] state_dbg;

   sd_spi_master #(.HI_FREQ_DIV(HI), .LO_FREQ_DIV(LO), .SPI_MODE(0)) dut (
      .clk(clk), .rst(rst), .clk_div(clk_div), .rd(rd), .wr(wr), .hold(hold),
      .wr_data(wr_data), .rd_data(rd_data), .done_tick(done_tick), .ready(ready),
      .miso(miso), .mosi(mosi), .sclk(sclk), .cs_n(cs_n), .state_dbg(state_dbg)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
   endtask

   // ---------------- scoreboard queues ----------------
   logic [7:0]  exp_q[$];
   logic [7:0]  tx_q[$];
   int unsigned cyc_q[$];
   logic [7:0]  slave_q[$];

   // ---------------- SPI slave model (mode 0), sampled on negedge clk ----------------
   logic [7:0] slave_sr = 8'hFF;
   logic [7:0] mosi_sr  = 8'h00;
   int         slave_bits = 0;
   bit         slave_pending = 1'b0;
   bit         prev_cs = 1'b1;
   bit         prev_sclk = 1'b0;
   int         sclk_rises = 0;
   assign miso = slave_sr[7];

   task automatic slave_load();
      if (slave_q.size() > 0) begin
         slave_sr      = slave_q.pop_front();
         slave_pending = 1'b0;
      end else begin
         slave_sr      = 8'hFF;
         slave_pending = 1'b1;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cs_n !== 1'b0) begin
            slave_bits    = 0;
            slave_pending = 1'b0;
         end else begin
            if (prev_cs) begin
               slave_bits = 0;
               slave_load();
            end else if (prev_sclk && sclk === 1'b0) begin
               slave_bits = slave_bits + 1;
               if (slave_bits == 8) begin
                  slave_bits = 0;
                  slave_load();
               end else begin
                  slave_sr = {slave_sr[6:0], 1'b1};
               end
            end
            if (!prev_sclk && sclk === 1'b1) begin
               mosi_sr    = {mosi_sr[6:0], mosi};
               sclk_rises = sclk_rises + 1;
            end
            if (slave_pending && slave_q.size() > 0) slave_load();
         end
         prev_cs   = (cs_n !== 1'b0);
         prev_sclk = (sclk === 1'b1);
      end
   end

   // ---------------- monitor ----------------
   int cs_high_cyc = 0, ready_hi_cyc = 0, mosi_low_cyc = 0, done_count = 0;
   logic [7:0]  m_rd, m_tx;
   int unsigned m_cyc;

   initial begin
      forever begin
         @(negedge clk);
         if (cs_n === 1'b1) cs_high_cyc = cs_high_cyc + 1;
         if (ready === 1'b1) ready_hi_cyc = ready_hi_cyc + 1;
         if (mosi === 1'b0) mosi_low_cyc = mosi_low_cyc + 1;
         if (!rst && done_tick === 1'b1) begin
            done_count = done_count + 1;
            if (exp_q.size() == 0) begin
               timeout_fail("unexpected_done_tick");
            end else begin
               m_rd  = exp_q.pop_front();
               m_tx  = tx_q.pop_front();
               m_cyc = cyc_q.pop_front();
               check("rd_data", rd_data, m_rd);
               check("mosi_byte", mosi_sr, m_tx);
               check("done_latency_cycle", cyc, m_cyc);
               check("ready_low_at_done", ready, 1'b0);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic is_wr, input logic [7:0] data, input logic h,
                        input logic div, input logic [7:0] sl);
      int n;
      logic [7:0] tx;
      n = 0;
      while (!(ready === 1'b1 || done_tick === 1'b1) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) timeout_fail("issue_wait");
      tx      = is_wr ? data : 8'hFF;
      wr      = is_wr;
      rd      = !is_wr;
      wr_data = is_wr ? data : 8'h00;
      hold    = h;
      clk_div = div;
      exp_q.push_back(LB ? tx : sl);
      tx_q.push_back(tx);
      cyc_q.push_back(cyc + 8 * (div ? HI : LO));
      slave_q.push_back(sl);
      @(negedge clk);
      wr = 1'b0;
      rd = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_tick !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (done_tick !== 1'b1) timeout_fail("done_wait");
   endtask

   task automatic check_idle(input string tag, input logic exp_cs);
      check({tag, "_ready"}, ready, 1'b1);
      check({tag, "_cs_n"}, cs_n, exp_cs);
      check({tag, "_mosi"}, mosi, 1'b1);
      check({tag, "_sclk"}, sclk, 1'b0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      timeout_fail("global_watchdog");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- directed sequence ----------------
   logic [7:0] chain_tx [6];
   logic [7:0] chain_sl [6];
   int snap_a, snap_b, snap_c, snap_d;

   initial begin
      chain_tx = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
      chain_sl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

      // 1: reset values
      repeat (3) @(negedge clk);
      check_idle("rst", 1'b1);
      check("rst_rd_data", rd_data, 8'h00);
      check("rst_done_tick", done_tick, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_rst", 1'b1);
      check("post_rst_state", state_dbg, 2'd0);

      // 2: fast write 0x40, slave answers 0x01
      issue(1'b1, 8'h40, 1'b0, 1'b1, 8'h01);
      check("xfer_cs_low", cs_n, 1'b0);
      check("xfer_ready_low", ready, 1'b0);
      wait_done(500);
      @(negedge clk);
      check_idle("after_wr", 1'b1);

      // 3: slow read with miso held high; rd_data must hold mid-byte
      issue(1'b0, 8'h00, 1'b0, 1'b0, 8'hFF);
      snap_a = mosi_low_cyc;
      repeat (4 * LO) @(negedge clk);
      check("rd_data_hold_midbyte", rd_data, LB ? 8'h40 : 8'h01);
      wait_done(5000);
      check("rd_mosi_stays_high", mosi_low_cyc - snap_a, 0);
      @(negedge clk);
      check_idle("after_rd", 1'b1);

      // 4: six chained writes at the fast rate
      snap_d = done_count;
      issue(1'b1, chain_tx[0], 1'b0, 1'b1, chain_sl[0]);
      snap_a = cs_high_cyc;
      snap_b = ready_hi_cyc;
      snap_c = sclk_rises;
      for (int i = 1; i < 6; i++) begin
         wait_done(500);
         issue(1'b1, chain_tx[i], 1'b0, 1'b1, chain_sl[i]);
      end
      wait_done(500);
      check("chain_cs_never_high", cs_high_cyc - snap_a, 0);
      check("chain_ready_never_high", ready_hi_cyc - snap_b, 0);
      check("chain_sclk_rises", sclk_rises - snap_c, 48);
      check("chain_done_count", done_count - snap_d, 6);
      @(negedge clk);
      check_idle("after_chain", 1'b1);

      // 5: write with hold, then a read reusing the low chip select
      issue(1'b1, 8'hA5, 1'b1, 1'b1, 8'h3C);
      wait_done(500);
      @(negedge clk);
      check_idle("hold_idle", 1'b0);
      check("hold_state", state_dbg, 2'd2);
      repeat (5) @(negedge clk);
      snap_a = cs_high_cyc;
      issue(1'b0, 8'h00, 1'b0, 1'b1, 8'hC3);
      check("hold_next_ready_low", ready, 1'b0);
      wait_done(500);
      check("hold_cs_never_high", cs_high_cyc - snap_a, 0);
      @(negedge clk);
      check_idle("after_hold_rd", 1'b1);

      // 6: reset in bit 4 of a byte
      issue(1'b1, 8'h5A, 1'b0, 1'b1, 8'h77);
      repeat (4 * HI + HI / 2 - 1) @(negedge clk);
      check("abort_pre_cs_low", cs_n, 1'b0);
      snap_d = done_count;
      rst = 1'b1;
      #1;
      check_idle("abort", 1'b1);
      check("abort_rd_data", rd_data, 8'h00);
      check("abort_done_tick", done_tick, 1'b0);
      exp_q.delete();
      tx_q.delete();
      cyc_q.delete();
      slave_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (10 * HI) @(negedge clk);
      check("abort_no_done", done_count - snap_d, 0);

      // recovery byte after the abort
      issue(1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A);
      wait_done(500);
      @(negedge clk);
      check_idle("after_recovery", 1'b1);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
